// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Branch resolution stage for the KGP-miniRISC pipeline. Keeps the
// architectural sign/zero/carry flags, decides whether a branch presented by
// decode is taken, computes its target and drives a registered redirect
// handshake towards fetch, followed by a programmable flush window. Decode is
// stalled (br_ready low) from the accept of a taken branch until the flush
// window has ended.
//
// Optional feature macro: BRU_RAS_EN
//   defined   -> RAS_DEPTH-entry circular return stack. BL pushes br_pc+1,
//                BR pops and uses the popped address as its target. A BR on
//                an empty stack falls back to br_reg_target and raises the
//                sticky ras_underflow output.
//   undefined -> no stack. BR always goes to br_reg_target and the
//                ras_underflow port does not exist.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flag_we, flag_s/z/c      flag register write and incoming ALU flags
//   br_valid / br_ready      branch handshake from decode
//   br_sel                   branch select (br_sel[3]=0 means no branch)
//   br_pc, br_offset         branch PC and signed PC-relative offset
//   br_reg_target            register-indirect target for BR
//   redir_valid / redir_ready / redir_pc   redirect handshake to fetch
//   flush                    squash younger stages
//   link_we, link_data       one-cycle link write strobe and return address
//   taken_cnt                saturating count of taken branches
//   ras_underflow            sticky stack underflow (BRU_RAS_EN only)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
   parameter int ADDR_W       = 32,
   parameter int OFF_W        = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16,
   parameter int RAS_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flag_we,
   input  logic              flag_s,
   input  logic              flag_z,
   input  logic              flag_c,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_sel,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [OFF_W-1:0]  br_offset,
   input  logic [ADDR_W-1:0] br_reg_target,
   output logic              redir_valid,
   input  logic              redir_ready,
   output logic [ADDR_W-1:0] redir_pc,
   output logic              flush,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data,
   output logic [CNT_W-1:0]  taken_cnt
`ifdef BRU_RAS_EN
   ,
   output logic              ras_underflow
`endif
);

   localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t            state;
   logic [FCNT_W-1:0] flushCnt;
   logic              flagS;
   logic              flagZ;
   logic              flagC;

   logic              effS;
   logic              effZ;
   logic              effC;
   logic              condMet;
   logic              accept;
   logic              isBl;
   logic              isBr;
   logic              takenNow;
   logic [ADDR_W-1:0] seqPc;
   logic [ADDR_W-1:0] relTarget;
   logic [ADDR_W-1:0] branchTarget;

`ifdef BRU_RAS_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int RCNT_W = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] rasStack [RAS_DEPTH];
   logic [PTR_W-1:0]  rasPtr;
   logic [RCNT_W-1:0] rasCount;
   logic              rasEmpty;
   logic [ADDR_W-1:0] rasTop;
`endif

   // Decode is only accepted while idle and never while reset is held, so
   // br_ready reads 0 during reset and 1 once reset has been released.
   assign br_ready = (state == IDLE) && !rst;
   assign accept   = br_valid && br_ready;

   // Condition evaluation. A flag write arriving in the same cycle as the
   // branch is forwarded so the branch sees the newest ALU result.
   always_comb begin
      effS    = flag_we ? flag_s : flagS;
      effZ    = flag_we ? flag_z : flagZ;
      effC    = flag_we ? flag_c : flagC;
      condMet = 1'b0;
      case (br_sel[2:0])
         3'b000:  condMet = 1'b1;
         3'b001:  condMet = 1'b1;
         3'b010:  condMet = effS;
         3'b011:  condMet = effZ;
         3'b100:  condMet = !effZ;
         3'b101:  condMet = 1'b1;
         3'b110:  condMet = effC;
         3'b111:  condMet = !effC;
         default: condMet = 1'b0;
      endcase
      takenNow = br_sel[3] && condMet;
      isBl     = (br_sel == 4'b1101);
      isBr     = (br_sel == 4'b1000);
   end

`ifdef BRU_RAS_EN
   assign rasEmpty = (rasCount == '0);
   assign rasTop   = rasStack[rasPtr - PTR_W'(1)];
`endif

   // Target generation. PC-relative targets wrap modulo 2^ADDR_W; BR takes
   // the popped return address when the stack has one.
   always_comb begin
      seqPc     = br_pc + ADDR_W'(1);
      relTarget = seqPc + ADDR_W'($signed(br_offset));
      if (isBr) begin
`ifdef BRU_RAS_EN
         branchTarget = rasEmpty ? br_reg_target : rasTop;
`else
         branchTarget = br_reg_target;
`endif
      end else begin
         branchTarget = relTarget;
      end
   end

   // Architectural flag register; written whenever flag_we is high,
   // independent of branch traffic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flagS <= 1'b0;
         flagZ <= 1'b0;
         flagC <= 1'b0;
      end else if (flag_we) begin
         flagS <= flag_s;
         flagZ <= flag_z;
         flagC <= flag_c;
      end
   end

   // Redirect/flush sequencer with all handshake outputs registered. The
   // link strobe is a single-cycle pulse issued on BL accept regardless of
   // how long fetch takes to accept the redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         flushCnt    <= '0;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
         flush       <= 1'b0;
         link_we     <= 1'b0;
         link_data   <= '0;
         taken_cnt   <= '0;
      end else begin
         link_we <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (isBl) begin
                     link_we   <= 1'b1;
                     link_data <= seqPc;
                  end
                  if (takenNow) begin
                     state       <= REDIRECT;
                     redir_valid <= 1'b1;
                     redir_pc    <= branchTarget;
                     if (taken_cnt != '1) begin
                        taken_cnt <= taken_cnt + CNT_W'(1);
                     end
                  end
               end
            end
            REDIRECT: begin
               if (redir_ready) begin
                  redir_valid <= 1'b0;
                  if (FLUSH_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state    <= FLUSH;
                     flush    <= 1'b1;
                     flushCnt <= FCNT_W'(FLUSH_CYCLES - 1);
                  end
               end
            end
            FLUSH: begin
               if (flushCnt == '0) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  flushCnt <= flushCnt - FCNT_W'(1);
               end
            end
            default: begin
               state       <= IDLE;
               redir_valid <= 1'b0;
               flush       <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRU_RAS_EN
   // Stack storage needs no reset: emptiness is tracked by rasCount.
   always_ff @(posedge clk) begin
      if (accept && isBl) begin
         rasStack[rasPtr] <= seqPc;
      end
   end

   // Stack pointer and occupancy. When full, a push overwrites the oldest
   // entry because the pointer simply wraps while the count saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rasPtr        <= '0;
         rasCount      <= '0;
         ras_underflow <= 1'b0;
      end else if (accept) begin
         if (isBl) begin
            rasPtr <= rasPtr + PTR_W'(1);
            if (rasCount != RCNT_W'(RAS_DEPTH)) begin
               rasCount <= rasCount + RCNT_W'(1);
            end
         end else if (isBr) begin
            if (rasEmpty) begin
               ras_underflow <= 1'b1;
            end else begin
               rasPtr   <= rasPtr - PTR_W'(1);
               rasCount <= rasCount - RCNT_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit. A default-parameter instance
// is exercised with a table of single-branch vectors plus hand-written
// sequences for stalls, reset during flush and back-to-back not-taken
// branches. A second instance (CNT_W=2, FLUSH_CYCLES=0) covers counter
// saturation and the zero-length flush. The return stack is exercised when
// BRU_RAS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

   typedef struct {
      logic [2:0]  pre;
      logic        fwdWe;
      logic [2:0]  fwd;
      logic [3:0]  sel;
      logic [31:0] pc;
      logic [15:0] off;
      logic [31:0] regT;
      logic        expTaken;
      logic [31:0] expTarget;
      logic        expLink;
      logic [31:0] expLinkData;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flagWe = 1'b0;
   logic        flagS = 1'b0;
   logic        flagZ = 1'b0;
   logic        flagC = 1'b0;
   logic        brValid = 1'b0;
   logic        brValidSmall = 1'b0;
   logic [3:0]  brSel = 4'b0000;
   logic [31:0] brPc = '0;
   logic [15:0] brOffset = '0;
   logic [31:0] brRegTarget = '0;
   logic        redirReady = 1'b1;

   logic        brReady;
   logic        redirValid;
   logic [31:0] redirPc;
   logic        flushSig;
   logic        linkWe;
   logic [31:0] linkData;
   logic [15:0] takenCnt;
`ifdef BRU_RAS_EN
   logic        rasUnderflow;
   logic        smRasUnderflow;
`endif

   logic        smReady;
   logic        smRedirValid;
   logic [31:0] smRedirPc;
   logic        smFlush;
   logic        smLinkWe;
   logic [31:0] smLinkData;
   logic [1:0]  smTakenCnt;

   int          checks = 0;
   int          failures = 0;
   int          expCnt = 0;
   logic        capValid;
   logic [31:0] capPc;
   vec_t        vecs [14];

   branch_resolve_unit dut (
      .clk(clk), .rst(rst),
      .flag_we(flagWe), .flag_s(flagS), .flag_z(flagZ), .flag_c(flagC),
      .br_valid(brValid), .br_ready(brReady), .br_sel(brSel),
      .br_pc(brPc), .br_offset(brOffset), .br_reg_target(brRegTarget),
      .redir_valid(redirValid), .redir_ready(redirReady), .redir_pc(redirPc),
      .flush(flushSig), .link_we(linkWe), .link_data(linkData),
      .taken_cnt(takenCnt)
`ifdef BRU_RAS_EN
      , .ras_underflow(rasUnderflow)
`endif
   );

   branch_resolve_unit #(.CNT_W(2), .FLUSH_CYCLES(0)) dutSmall (
      .clk(clk), .rst(rst),
      .flag_we(flagWe), .flag_s(flagS), .flag_z(flagZ), .flag_c(flagC),
      .br_valid(brValidSmall), .br_ready(smReady), .br_sel(brSel),
      .br_pc(brPc), .br_offset(brOffset), .br_reg_target(brRegTarget),
      .redir_valid(smRedirValid), .redir_ready(redirReady), .redir_pc(smRedirPc),
      .flush(smFlush), .link_we(smLinkWe), .link_data(smLinkData),
      .taken_cnt(smTakenCnt)
`ifdef BRU_RAS_EN
      , .ras_underflow(smRasUnderflow)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; all driving and sampling
   // happens at this point, away from the active edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Issue one branch and, if it redirects, let it run to completion.
   // Captures the redirect state seen right after accept.
   task automatic issueBranch(input logic [3:0] sel, input logic [31:0] pc,
                              input logic [15:0] off, input logic [31:0] regT);
      bit done;
      flagWe      = 1'b0;
      brSel       = sel;
      brPc        = pc;
      brOffset    = off;
      brRegTarget = regT;
      brValid     = 1'b1;
      checkOutput("issueReady", {31'd0, brReady}, 32'd1);
      stepClk();
      brValid  = 1'b0;
      capValid = redirValid;
      capPc    = redirPc;
      done     = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (brReady) done = 1'b1;
         else stepClk();
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL idleTimeout actual=busy expected=idle");
      end
   endtask

   // Run one table vector: load the registered flags, present the branch
   // (optionally with a forwarded flag write), then check the result and
   // the complete redirect/flush sequence.
   task automatic applyStimulus(input vec_t v);
      flagWe = 1'b1;
      {flagS, flagZ, flagC} = v.pre;
      brValid = 1'b0;
      stepClk();
      flagWe = v.fwdWe;
      {flagS, flagZ, flagC} = v.fwd;
      brSel       = v.sel;
      brPc        = v.pc;
      brOffset    = v.off;
      brRegTarget = v.regT;
      brValid     = 1'b1;
      redirReady  = 1'b1;
      checkOutput("vecReady", {31'd0, brReady}, 32'd1);
      stepClk();
      brValid = 1'b0;
      flagWe  = 1'b0;
      if (v.expTaken) expCnt++;
      checkOutput("vecRedirValid", {31'd0, redirValid}, {31'd0, v.expTaken});
      if (v.expTaken) checkOutput("vecRedirPc", redirPc, v.expTarget);
      checkOutput("vecLinkWe", {31'd0, linkWe}, {31'd0, v.expLink});
      if (v.expLink) checkOutput("vecLinkData", linkData, v.expLinkData);
      checkOutput("vecBrReady", {31'd0, brReady}, {31'd0, !v.expTaken});
      checkOutput("vecTakenCnt", {16'd0, takenCnt}, expCnt);
      if (v.expTaken) begin
         stepClk();
         checkOutput("vecFlush1", {31'd0, flushSig}, 32'd1);
         checkOutput("vecRedirDrop", {31'd0, redirValid}, 32'd0);
         checkOutput("vecLinkPulse", {31'd0, linkWe}, 32'd0);
         stepClk();
         checkOutput("vecFlush2", {31'd0, flushSig}, 32'd1);
         checkOutput("vecBusy", {31'd0, brReady}, 32'd0);
         stepClk();
         checkOutput("vecFlushEnd", {31'd0, flushSig}, 32'd0);
         checkOutput("vecIdle", {31'd0, brReady}, 32'd1);
      end
   endtask

   initial begin
      // {pre SZC, fwdWe, fwd SZC, sel, pc, offset, regTarget,
      //  taken, target, link, linkData}
      vecs[0]  = '{3'b010, 1'b0, 3'b000, 4'b1011, 32'h0000_0100, 16'hFFFC, 32'h0, 1'b1, 32'h0000_00FD, 1'b0, 32'h0};
      vecs[1]  = '{3'b000, 1'b1, 3'b010, 4'b1100, 32'h0000_0100, 16'h0000, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[2]  = '{3'b000, 1'b0, 3'b000, 4'b1100, 32'h0000_0200, 16'h0010, 32'h0, 1'b1, 32'h0000_0211, 1'b0, 32'h0};
      vecs[3]  = '{3'b100, 1'b0, 3'b000, 4'b1010, 32'h0000_0000, 16'h7FFF, 32'h0, 1'b1, 32'h0000_8000, 1'b0, 32'h0};
      vecs[4]  = '{3'b000, 1'b1, 3'b100, 4'b1010, 32'h0000_0300, 16'h0000, 32'h0, 1'b1, 32'h0000_0301, 1'b0, 32'h0};
      vecs[5]  = '{3'b000, 1'b0, 3'b000, 4'b1110, 32'h0000_0400, 16'h0004, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[6]  = '{3'b001, 1'b0, 3'b000, 4'b1110, 32'h0000_1000, 16'h8000, 32'h0, 1'b1, 32'hFFFF_9001, 1'b0, 32'h0};
      vecs[7]  = '{3'b000, 1'b0, 3'b000, 4'b1111, 32'hFFFF_FFFF, 16'h0000, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
      vecs[8]  = '{3'b000, 1'b1, 3'b001, 4'b1111, 32'h0000_0500, 16'h0000, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[9]  = '{3'b111, 1'b0, 3'b000, 4'b1001, 32'h0000_0040, 16'h0002, 32'h0, 1'b1, 32'h0000_0043, 1'b0, 32'h0};
      vecs[10] = '{3'b000, 1'b0, 3'b000, 4'b1000, 32'h0000_0050, 16'h0007, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[11] = '{3'b000, 1'b0, 3'b000, 4'b1101, 32'hFFFF_FFFF, 16'h0005, 32'h0, 1'b1, 32'h0000_0005, 1'b1, 32'h0000_0000};
      vecs[12] = '{3'b111, 1'b0, 3'b000, 4'b0011, 32'h0000_0060, 16'h0001, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0};
      vecs[13] = '{3'b101, 1'b0, 3'b000, 4'b1011, 32'h0000_0070, 16'h0001, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0};

      // Reset behaviour: outputs quiet while held, br_ready after release.
      stepClk();
      stepClk();
      checkOutput("rstBrReady", {31'd0, brReady}, 32'd0);
      checkOutput("rstRedirValid", {31'd0, redirValid}, 32'd0);
      rst = 1'b0;
      stepClk();
      checkOutput("postRstReady", {31'd0, brReady}, 32'd1);
      checkOutput("postRstCnt", {16'd0, takenCnt}, 32'd0);
      checkOutput("postRstFlush", {31'd0, flushSig}, 32'd0);
      checkOutput("postRstLinkWe", {31'd0, linkWe}, 32'd0);
      checkOutput("postRstRedirPc", redirPc, 32'd0);

      for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

      // BL with fetch stalling the redirect for three cycles.
      redirReady = 1'b0;
      flagWe     = 1'b0;
      brSel      = 4'b1101;
      brPc       = 32'h0000_0500;
      brOffset   = 16'h0010;
      brValid    = 1'b1;
      stepClk();
      brValid = 1'b0;
      expCnt++;
      checkOutput("stallLinkWe", {31'd0, linkWe}, 32'd1);
      checkOutput("stallLinkData", linkData, 32'h0000_0501);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) stepClk();
         checkOutput("stallRedirValid", {31'd0, redirValid}, 32'd1);
         checkOutput("stallRedirPc", redirPc, 32'h0000_0511);
         checkOutput("stallBrReady", {31'd0, brReady}, 32'd0);
         if (i > 0) checkOutput("stallLinkPulse", {31'd0, linkWe}, 32'd0);
      end
      redirReady = 1'b1;
      stepClk();
      checkOutput("stallFlush", {31'd0, flushSig}, 32'd1);
      checkOutput("stallRedirDrop", {31'd0, redirValid}, 32'd0);
      stepClk();
      stepClk();
      checkOutput("stallIdle", {31'd0, brReady}, 32'd1);
      checkOutput("stallCnt", {16'd0, takenCnt}, expCnt);

      // Not-taken branches every cycle: Z=1 registered, BNZ repeatedly.
      flagWe = 1'b1;
      {flagS, flagZ, flagC} = 3'b010;
      stepClk();
      flagWe  = 1'b0;
      brSel   = 4'b1100;
      brValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("b2bReadyBefore", {31'd0, brReady}, 32'd1);
         stepClk();
         checkOutput("b2bNoRedirect", {31'd0, redirValid}, 32'd0);
      end
      brValid = 1'b0;
      checkOutput("b2bCnt", {16'd0, takenCnt}, expCnt);

      // Reset asserted while the flush window is active.
      brSel    = 4'b1001;
      brPc     = 32'h0000_0060;
      brOffset = 16'h0000;
      brValid  = 1'b1;
      stepClk();
      brValid = 1'b0;
      checkOutput("preRstRedir", {31'd0, redirValid}, 32'd1);
      stepClk();
      checkOutput("preRstFlush", {31'd0, flushSig}, 32'd1);
      #1 rst = 1'b1;
      #1;
      checkOutput("midRstFlush", {31'd0, flushSig}, 32'd0);
      checkOutput("midRstRedir", {31'd0, redirValid}, 32'd0);
      checkOutput("midRstCnt", {16'd0, takenCnt}, 32'd0);
      checkOutput("midRstReady", {31'd0, brReady}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      stepClk();
      expCnt = 0;
      checkOutput("afterRstReady", {31'd0, brReady}, 32'd1);
      issueBranch(4'b1000, 32'h0000_0070, 16'h0000, 32'h0000_1234);
      expCnt++;
      checkOutput("afterRstBrValid", {31'd0, capValid}, 32'd1);
      checkOutput("afterRstBrPc", capPc, 32'h0000_1234);
      checkOutput("afterRstCnt", {16'd0, takenCnt}, expCnt);

      // Small instance: 2-bit counter saturates, no flush window.
      brSel    = 4'b1001;
      brPc     = 32'h0000_0000;
      brOffset = 16'h0000;
      for (int k = 1; k <= 4; k++) begin
         brValidSmall = 1'b1;
         checkOutput("smReadyBefore", {31'd0, smReady}, 32'd1);
         stepClk();
         brValidSmall = 1'b0;
         checkOutput("smTakenCnt", {30'd0, smTakenCnt}, (k < 3) ? k : 3);
         checkOutput("smRedirValid", {31'd0, smRedirValid}, 32'd1);
         checkOutput("smRedirPc", smRedirPc, 32'h0000_0001);
         stepClk();
         checkOutput("smRedirDrop", {31'd0, smRedirValid}, 32'd0);
         checkOutput("smNoFlush", {31'd0, smFlush}, 32'd0);
         checkOutput("smReadyAfter", {31'd0, smReady}, 32'd1);
      end

`ifdef BRU_RAS_EN
      // Return stack: five pushes into four entries, then five pops.
      rst = 1'b1;
      stepClk();
      rst = 1'b0;
      stepClk();
      for (int i = 0; i < 5; i++) issueBranch(4'b1101, 32'h10 + i, 16'h0000, 32'h0);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] expTgt;
         expTgt = (i < 4) ? (32'h15 - i) : 32'h99;
         issueBranch(4'b1000, 32'h80, 16'h0000, 32'h99);
         checkOutput("rasTarget", capPc, expTgt);
         checkOutput("rasUnderflow", {31'd0, rasUnderflow}, (i < 4) ? 32'd0 : 32'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout actual=running expected=finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
